pipe_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the pipelined MIPS CPU. It combines operand forwarding, load-use stalling and taken-branch flushing in one block. A shift-register scoreboard tracks every in-flight instruction from EX to WB, so pipeline depth and load latency are parameters rather than hard-wired compares. It sits beside the decode stage: ID-stage fields go in, and stall/flush controls plus registered EX forward selects come out.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_src_match.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// scoreboard slot record, forward-select encoding and select-width helper.
package pipe_hazard_ctrl_pkg;

  // Slot fields are sized for the largest register file / load latency in use.
  localparam int SLOT_ADDR_W = 8;
  localparam int SLOT_RDY_W  = 4;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] rd;
    logic                   reg_write;
    logic [SLOT_RDY_W-1:0]  rdy;
  } slot_t;

  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  function automatic int fwd_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Scans the scoreboard for the youngest in-flight writer of one source
// register and reports whether it can be forwarded or must stall.
module hazard_src_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_W  = 2
) (
  input  slot_t             i_slots [1:DEPTH-1],
  input  logic [ADDR_W-1:0] i_src,
  input  logic              i_use,
  output logic              o_hit,
  output logic              o_hazard,
  output logic [FWD_W-1:0]  o_sel
);

  logic [DEPTH-1:1] w_match;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_match
      assign w_match[gi] = i_slots[gi].valid && i_slots[gi].reg_write &&
                           (i_slots[gi].rd == SLOT_ADDR_W'(i_src));
    end
  endgenerate

  // Scan oldest to youngest so the smallest matching slot wins.
  always_comb begin
    o_hit    = 1'b0;
    o_hazard = 1'b0;
    o_sel    = '0;
    if (i_use && (i_src != '0)) begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        if (w_match[s]) begin
          o_hit    = 1'b1;
          o_sel    = FWD_W'(s);
          o_hazard = (SLOT_RDY_W'(s) < i_slots[s].rdy);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding, load-use stall and branch-flush control driven by a
// shift-register scoreboard of in-flight instructions (EX..WB).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int BR_STAGE = 2,
  parameter int FWD_W    = fwd_width(DEPTH),
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_is_load_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [FWD_W-1:0]  fwd_a_o,
  output logic [FWD_W-1:0]  fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The WB slot is never consulted (the register file bypasses it), so only
  // slots 1..DEPTH-1 hold state; the WB entry is the one shifted out.
  localparam int LIVE = DEPTH - 1;

  slot_t             r_slots [1:LIVE];
  logic [FWD_W-1:0]  r_fwd_a;
  logic [FWD_W-1:0]  r_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  slot_t             w_id_slot;
  logic              w_issue;
  logic              w_hit_rs, w_hit_rt;
  logic              w_haz_rs, w_haz_rt;
  logic [FWD_W-1:0]  w_sel_rs, w_sel_rt;

  hazard_src_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .FWD_W  (FWD_W)
  ) u_match_rs (
    .i_slots  (r_slots),
    .i_src    (id_rs_i),
    .i_use    (id_use_rs_i),
    .o_hit    (w_hit_rs),
    .o_hazard (w_haz_rs),
    .o_sel    (w_sel_rs)
  );

  hazard_src_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .FWD_W  (FWD_W)
  ) u_match_rt (
    .i_slots  (r_slots),
    .i_src    (id_rt_i),
    .i_use    (id_use_rt_i),
    .o_hit    (w_hit_rt),
    .o_hazard (w_haz_rt),
    .o_sel    (w_sel_rt)
  );

  assign flush_o = branch_taken_i;
  assign stall_o = id_valid_i & (w_haz_rs | w_haz_rt) & ~flush_o;
  assign w_issue = id_valid_i & ~stall_o & ~flush_o;

  always_comb begin
    w_id_slot = '0;
    if (w_issue) begin
      w_id_slot.valid     = 1'b1;
      w_id_slot.rd        = SLOT_ADDR_W'(id_rd_i);
      w_id_slot.reg_write = id_reg_write_i;
      w_id_slot.rdy       = id_is_load_i ? SLOT_RDY_W'(LOAD_RDY) : SLOT_RDY_W'(1);
    end
  end

  // Entries younger than the branch stage are wrong-path and die on flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 1; s <= LIVE; s++) begin
        r_slots[s] <= '0;
      end
    end else begin
      r_slots[1] <= w_id_slot;
      for (int s = LIVE; s >= 2; s--) begin
        r_slots[s] <= (flush_o && (s - 1 < BR_STAGE)) ? '0 : r_slots[s-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else begin
      r_fwd_a <= (w_issue && w_hit_rs) ? w_sel_rs : '0;
      r_fwd_b <= (w_issue && w_hit_rt) ? w_sel_rt : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fwd_a_o     = r_fwd_a;
  assign fwd_b_o     = r_fwd_b;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with default parameters:
// forwarding, load-use stall, $0, branch flush and reset mid-stall.
module tb_pipe_hazard_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_use_rs_i;
  logic        id_use_rt_i;
  logic [4:0]  id_rd_i;
  logic        id_reg_write_i;
  logic        id_is_load_i;
  logic        branch_taken_i;
  logic        stall_o;
  logic        flush_o;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
  logic [15:0] stall_cnt_o;

  int n_checks;
  int n_fail;

  pipe_hazard_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_use_rs_i    (id_use_rs_i),
    .id_use_rt_i    (id_use_rt_i),
    .id_rd_i        (id_rd_i),
    .id_reg_write_i (id_reg_write_i),
    .id_is_load_i   (id_is_load_i),
    .branch_taken_i (branch_taken_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .fwd_a_o        (fwd_a_o),
    .fwd_b_o        (fwd_b_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Present one ID-stage instruction just after the falling edge.
  task automatic id_in(input int v, input int rs, input int rt, input int urs, input int urt,
                       input int rd, input int rw, input int ld, input int br);
    @(negedge clk_i);
    id_valid_i     = 1'(v);
    id_rs_i        = 5'(rs);
    id_rt_i        = 5'(rt);
    id_use_rs_i    = 1'(urs);
    id_use_rt_i    = 1'(urt);
    id_rd_i        = 5'(rd);
    id_reg_write_i = 1'(rw);
    id_is_load_i   = 1'(ld);
    branch_taken_i = 1'(br);
    #1;
  endtask

  task automatic nop();
    id_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_ctl(input string tag, input int st, input int fl);
    check({tag, ".stall"}, 32'(stall_o), 32'(st));
    check({tag, ".flush"}, 32'(flush_o), 32'(fl));
  endtask

  task automatic chk_fwd(input string tag, input int a, input int b);
    check({tag, ".fwd_a"}, 32'(fwd_a_o), 32'(a));
    check({tag, ".fwd_b"}, 32'(fwd_b_o), 32'(b));
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_i          = 1'b0;
    id_valid_i     = 1'b0;
    id_rs_i        = '0;
    id_rt_i        = '0;
    id_use_rs_i    = 1'b0;
    id_use_rt_i    = 1'b0;
    id_rd_i        = '0;
    id_reg_write_i = 1'b0;
    id_is_load_i   = 1'b0;
    branch_taken_i = 1'b0;

    #1;
    chk_ctl("reset", 0, 0);
    chk_fwd("reset", 0, 0);
    check("reset.cnt", 32'(stall_cnt_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // ALU chain: add $2 ; add $3,$2,$2
    id_in(1, 1, 1, 1, 1, 2, 1, 0, 0);
    chk_ctl("alu_prod", 0, 0);
    id_in(1, 2, 2, 1, 1, 3, 1, 0, 0);
    chk_ctl("alu_cons", 0, 0);
    nop();
    chk_fwd("alu_ex", 1, 1);

    // Load-use: lw $2 ; add $4,$2,$5
    id_in(1, 29, 0, 1, 0, 2, 1, 1, 0);
    chk_ctl("lw_prod", 0, 0);
    chk_fwd("bubble", 0, 0);
    id_in(1, 2, 5, 1, 1, 4, 1, 0, 0);
    chk_ctl("lu_stall", 1, 0);
    check("lu_stall.cnt", 32'(stall_cnt_o), 0);
    id_in(1, 2, 5, 1, 1, 4, 1, 0, 0);
    chk_ctl("lu_release", 0, 0);
    check("lu_release.cnt", 32'(stall_cnt_o), 1);
    nop();
    chk_fwd("lu_ex", 2, 0);

    // Distance three: add $6, add $7, add $8, then add $9,$6,$8
    id_in(1, 1, 1, 1, 1, 6, 1, 0, 0);
    id_in(1, 1, 1, 1, 1, 7, 1, 0, 0);
    id_in(1, 1, 1, 1, 1, 8, 1, 0, 0);
    id_in(1, 6, 8, 1, 1, 9, 1, 0, 0);
    chk_ctl("dist3", 0, 0);
    nop();
    chk_fwd("dist3_ex", 0, 1);

    // $0 destination: lw $0 ; add $4,$0,$0
    id_in(1, 29, 0, 1, 0, 0, 1, 1, 0);
    id_in(1, 0, 0, 1, 1, 4, 1, 0, 0);
    chk_ctl("zero_reg", 0, 0);
    check("zero_reg.cnt", 32'(stall_cnt_o), 1);
    nop();
    chk_fwd("zero_ex", 0, 0);

    // Branch flush while ID holds a load-use consumer
    id_in(1, 29, 0, 1, 0, 10, 1, 1, 0);
    id_in(1, 10, 10, 1, 1, 11, 1, 0, 1);
    chk_ctl("br_flush", 0, 1);
    id_in(1, 10, 1, 1, 1, 12, 1, 0, 0);
    chk_ctl("post_flush", 0, 0);
    check("post_flush.cnt", 32'(stall_cnt_o), 1);
    chk_fwd("flushed_slot", 0, 0);
    nop();
    chk_fwd("post_flush_ex", 0, 0);

    // Reset asserted while a load-use stall is active
    id_in(1, 29, 0, 1, 0, 13, 1, 1, 0);
    id_in(1, 13, 13, 1, 1, 14, 1, 0, 0);
    chk_ctl("pre_rst", 1, 0);
    check("pre_rst.cnt", 32'(stall_cnt_o), 1);
    #1 rst_i = 1'b0;
    #1;
    check("mid_rst.cnt", 32'(stall_cnt_o), 0);
    check("mid_rst.stall", 32'(stall_o), 0);
    chk_fwd("mid_rst", 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk_ctl("after_rst", 0, 0);
    check("after_rst.cnt", 32'(stall_cnt_o), 0);
    nop();
    chk_fwd("after_rst_ex", 0, 0);
    check("after_rst_ex.cnt", 32'(stall_cnt_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
